// File: rtl/mult_pkg.sv
// Shared types and widths for the serial-multiplier feeder.
package mult_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  // Dispatch sequence: send both operands, wait for the product, fetch it, hold it for the client.
  typedef enum logic [2:0] {
    IDLE,
    PUT_A,
    PUT_B,
    WAIT,
    GET,
    HOLD
  } state_t;

endpackage

// File: rtl/mult_feeder_fifo.sv
// Operand-pair FIFO: power-of-two depth, head word always visible on rdata.
module mult_feeder_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO ignores push even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mult_feeder.sv
// Queues operand pairs and drives them one at a time through a serial multiplier,
// holding each product until the client takes it; flags a sticky error on timeout.
module mult_feeder
  import mult_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              m_put,
  output logic [DATA_W-1:0] m_idata,
  output logic              m_get,
  input  logic              m_ready,
  input  logic              m_result_valid,
  input  logic [PROD_W-1:0] m_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic              err,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state;
  state_t              state_next;
  logic [2*DATA_W-1:0] head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [CNT_W-1:0]    wait_cnt;
  logic                timeout_hit;

  mult_feeder_fifo #(
    .WIDTH(2 * DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid),
    .pop  (fifo_pop),
    .wdata({in_a, in_b}),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign in_ready    = !fifo_full;
  assign busy        = (state != IDLE) || !fifo_empty;
  assign timeout_hit = (state == WAIT) && !m_result_valid
                       && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and multiplier strobes; strobes and operand bus are zero outside the states that use them.
  always_comb begin
    state_next = state;
    m_put      = 1'b0;
    m_get      = 1'b0;
    m_idata    = '0;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && m_ready) state_next = PUT_A;
      end
      PUT_A: begin
        m_put      = 1'b1;
        m_idata    = head[2*DATA_W-1:DATA_W];
        state_next = PUT_B;
      end
      PUT_B: begin
        m_put      = 1'b1;
        m_idata    = head[DATA_W-1:0];
        fifo_pop   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (m_result_valid)   state_next = GET;
        else if (timeout_hit) state_next = IDLE;
      end
      GET: begin
        m_get      = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Wait-cycle counter restarts as each transaction enters WAIT; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == PUT_B) begin
        wait_cnt <= '0;
      end else if ((state == WAIT) && !m_result_valid) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) err <= 1'b1;
    end
  end

  // Product register: loaded when fetched, held stable until the client accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
    end else if (state == GET) begin
      out_valid <= 1'b1;
      out_prod  <= m_result;
    end else if ((state == HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_feeder.sv
// Directed self-checking bench for mult_feeder with a behavioural serial multiplier.
module tb_mult_feeder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        m_put;
  logic [7:0]  m_idata;
  logic        m_get;
  logic        m_ready;
  logic        m_result_valid;
  logic [15:0] m_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        err;
  logic        busy;

  logic        ready_en;
  logic        suppress;
  logic        flush;

  logic        model_busy;
  logic        put_phase;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  int          lat;
  int          get_cnt;
  logic [7:0]  put_log [$];

  int total;
  int bad;

  logic [7:0]  fill_a [4] = '{8'd1, 8'd3, 8'd10, 8'd15};
  logic [7:0]  fill_b [4] = '{8'd2, 8'd4, 8'd20, 8'd15};
  logic [15:0] fill_p [4] = '{16'd2, 16'd12, 16'd200, 16'd225};

  mult_feeder #(
    .DEPTH  (4),
    .TIMEOUT(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .m_put         (m_put),
    .m_idata       (m_idata),
    .m_get         (m_get),
    .m_ready       (m_ready),
    .m_result_valid(m_result_valid),
    .m_result      (m_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_prod      (out_prod),
    .err           (err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_ready = ready_en && !model_busy;

  // Serial multiplier stand-in plus strobe logging, evaluated on the falling edge.
  always @(negedge clk) begin
    if (m_put) put_log.push_back(m_idata);
    if (m_get) get_cnt <= get_cnt + 1;
    if (rst || flush) begin
      model_busy     <= 1'b0;
      put_phase      <= 1'b0;
      m_result_valid <= 1'b0;
      m_result       <= '0;
      lat            <= 0;
    end else begin
      if (m_get) begin
        m_result_valid <= 1'b0;
        model_busy     <= 1'b0;
      end
      if (m_put) begin
        if (!put_phase) begin
          op_a      <= m_idata;
          put_phase <= 1'b1;
        end else begin
          op_b       <= m_idata;
          put_phase  <= 1'b0;
          model_busy <= 1'b1;
          lat        <= 3;
        end
      end else if (model_busy && !m_result_valid && lat > 0) begin
        lat <= lat - 1;
        if (lat == 1 && !suppress) begin
          m_result       <= {8'd0, op_a} * {8'd0, op_b};
          m_result_valid <= 1'b1;
        end
      end
    end
  end

  initial get_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput("out_valid_wait", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic acceptOutput();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
  endtask

  // Hard stop in case the sequence stalls somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g0;
    int p0;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    ready_en  = 1'b1;
    suppress  = 1'b0;
    flush     = 1'b0;

    tick();
    tick();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_prod", {16'd0, out_prod}, 32'd0);
    checkOutput("rst_m_put", {31'd0, m_put}, 32'd0);
    checkOutput("rst_m_get", {31'd0, m_get}, 32'd0);
    checkOutput("rst_m_idata", {24'd0, m_idata}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] basic 5x7");
    g0 = get_cnt;
    p0 = put_log.size();
    applyStimulus(8'd5, 8'd7);
    checkOutput("basic_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("put_a_strobe", {31'd0, m_put}, 32'd1);
    checkOutput("put_a_data", {24'd0, m_idata}, 32'd5);
    tick();
    checkOutput("put_b_strobe", {31'd0, m_put}, 32'd1);
    checkOutput("put_b_data", {24'd0, m_idata}, 32'd7);
    tick();
    checkOutput("wait_m_put", {31'd0, m_put}, 32'd0);
    checkOutput("wait_m_idata", {24'd0, m_idata}, 32'd0);
    waitOutValid(20);
    checkOutput("basic_prod", {16'd0, out_prod}, 32'h0023);
    checkOutput("basic_get_count", get_cnt - g0, 32'd1);
    checkOutput("basic_put_count", put_log.size() - p0, 32'd2);
    checkOutput("hold_m_get", {31'd0, m_get}, 32'd0);
    acceptOutput();

    $display("[TB] 255x255 with long hold");
    applyStimulus(8'd255, 8'd255);
    waitOutValid(20);
    checkOutput("max_prod", {16'd0, out_prod}, 32'hFE01);
    p0 = put_log.size();
    applyStimulus(8'd3, 8'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_prod", {16'd0, out_prod}, 32'hFE01);
    end
    checkOutput("hold_no_put", put_log.size() - p0, 32'd0);
    acceptOutput();
    waitOutValid(20);
    checkOutput("queued_prod", {16'd0, out_prod}, 32'h000C);
    acceptOutput();

    $display("[TB] fill FIFO with dispatch stalled");
    ready_en = 1'b0;
    p0 = put_log.size();
    for (int i = 0; i < 4; i++) applyStimulus(fill_a[i], fill_b[i]);
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(8'd9, 8'd9);
    checkOutput("full_still_full", {31'd0, in_ready}, 32'd0);
    checkOutput("stall_no_put", put_log.size() - p0, 32'd0);
    ready_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitOutValid(40);
      checkOutput("fifo_order_prod", {16'd0, out_prod}, {16'd0, fill_p[i]});
      acceptOutput();
    end
    tick();
    tick();
    checkOutput("fifo_drained_busy", {31'd0, busy}, 32'd0);
    checkOutput("fifo_put_count", put_log.size() - p0, 32'd8);

    $display("[TB] timeout");
    suppress = 1'b1;
    g0 = get_cnt;
    applyStimulus(8'd6, 8'd6);
    repeat (66) tick();
    checkOutput("timeout_err_early", {31'd0, err}, 32'd0);
    tick();
    checkOutput("timeout_err", {31'd0, err}, 32'd1);
    checkOutput("timeout_idle", {31'd0, busy}, 32'd0);
    checkOutput("timeout_no_get", get_cnt - g0, 32'd0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    suppress = 1'b0;
    applyStimulus(8'd7, 8'd8);
    waitOutValid(20);
    checkOutput("after_timeout_prod", {16'd0, out_prod}, 32'h0038);
    checkOutput("err_sticky", {31'd0, err}, 32'd1);
    acceptOutput();

    $display("[TB] reset during WAIT");
    suppress = 1'b1;
    g0 = get_cnt;
    applyStimulus(8'd2, 8'd3);
    applyStimulus(8'd4, 8'd5);
    applyStimulus(8'd6, 8'd7);
    repeat (3) tick();
    checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_out_prod", {16'd0, out_prod}, 32'd0);
    checkOutput("mid_rst_m_put", {31'd0, m_put}, 32'd0);
    checkOutput("mid_rst_m_get", {31'd0, m_get}, 32'd0);
    checkOutput("mid_rst_m_idata", {24'd0, m_idata}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
    rst      = 1'b0;
    suppress = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("post_rst_no_get", get_cnt - g0, 32'd0);
    applyStimulus(8'd12, 8'd12);
    waitOutValid(20);
    checkOutput("recovery_prod", {16'd0, out_prod}, 32'h0090);
    acceptOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
